// File: rtl/pg_gen_v2.sv
// Multi-pixel-per-clock video pattern generator: timing engine plus per-port pattern datapath.
// Define PG_AUTO_EN to build the auto-advance mode (key_auto toggles, AUTO_FRAMES per pattern).
module pg_gen_v2 #(
  parameter int unsigned H_ACT       = 2048,
  parameter int unsigned H_PW        = 42,
  parameter int unsigned H_BP        = 20,
  parameter int unsigned H_FP        = 90,
  parameter int unsigned V_ACT       = 2048,
  parameter int unsigned V_PW        = 2,
  parameter int unsigned V_BP        = 2,
  parameter int unsigned V_FP        = 192,
  parameter int unsigned PORTS       = 1,
  parameter int unsigned BPC         = 8,
  parameter int unsigned AUTO_FRAMES = 60
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     key_up,
  input  logic                     key_down,
  input  logic                     key_auto,
  output logic                     frm_st,
  output logic                     de,
  output logic                     vsync,
  output logic                     hsync,
  output logic [2:0]               mode,
  output logic [PORTS*3*BPC-1:0]   data
);

  localparam int unsigned H_TOT   = (H_PW + H_BP + H_ACT + H_FP) / PORTS;
  localparam int unsigned V_TOT   = V_PW + V_BP + V_ACT + V_FP;
  localparam int unsigned HW      = $clog2(H_TOT);
  localparam int unsigned VW      = $clog2(V_TOT);
  localparam int unsigned H_SYNC  = H_PW / PORTS;
  localparam int unsigned H_START = (H_PW + H_BP) / PORTS;
  localparam int unsigned H_END   = H_START + H_ACT / PORTS;
  localparam int unsigned V_START = V_PW + V_BP;
  localparam int unsigned V_END   = V_START + V_ACT;
  localparam int unsigned BAR_W   = H_ACT / 8;
  localparam int unsigned CW      = 16;
  // Bar colours {R,G,B}, bar 0 in the low bits: white..black.
  localparam logic [23:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                     3'b010, 3'b011, 3'b110, 3'b111};

  logic          en_q;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          frame_start;
  logic          up_q, down_q, up_rise, down_rise;
  logic [2:0]    pending_q, pending_d, mode_q, mode_d;

  // Counters only run once en has been seen for a cycle, so a restart begins at h=v=0.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en || !en_q) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == HW'(H_TOT - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VW'(V_TOT - 1)) ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  assign frame_start = en && en_q && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign up_rise     = key_up & ~up_q;
  assign down_rise   = key_down & ~down_q;

`ifdef PG_AUTO_EN
  localparam int unsigned FW = $clog2(AUTO_FRAMES) + 1;
  logic          auto_q, auto_d, auto_prev_q, auto_rise;
  logic [FW-1:0] fcnt_q, fcnt_d;

  assign auto_rise = key_auto & ~auto_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_q      <= 1'b0;
      auto_prev_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      auto_q      <= auto_d;
      auto_prev_q <= key_auto;
      fcnt_q      <= fcnt_d;
    end
  end
`else
  logic unused_key_auto;
  assign unused_key_auto = key_auto;
`endif

  always_comb begin
    pending_d = pending_q;
    mode_d    = mode_q;
    if (up_rise && !down_rise) begin
      pending_d = pending_q + 3'd1;
    end else if (down_rise && !up_rise) begin
      pending_d = pending_q - 3'd1;
    end
    if (frame_start) begin
      mode_d = pending_q;
    end
`ifdef PG_AUTO_EN
    auto_d = auto_rise ? ~auto_q : auto_q;
    fcnt_d = fcnt_q;
    if (!auto_q) begin
      fcnt_d = '0;
    end else if (frame_start) begin
      if (fcnt_q == FW'(AUTO_FRAMES - 1)) begin
        // Auto advance wins over any key edge in the same cycle.
        fcnt_d    = '0;
        pending_d = pending_q + 3'd1;
        mode_d    = pending_q + 3'd1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      pending_q <= 3'd0;
      mode_q    <= 3'd0;
    end else begin
      en_q      <= en;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      up_q      <= key_up;
      down_q    <= key_down;
      pending_q <= pending_d;
      mode_q    <= mode_d;
    end
  end

  // Stage 1: timing decode and pixel coordinates.
  logic          s1_fs, s1_de, s1_hs, s1_vs;
  logic [2:0]    s1_mode;
  logic [CW-1:0] s1_x, s1_y, x_base, y_base;
  logic          h_act, v_act;

  assign h_act  = (32'(h_cnt_q) >= H_START) && (32'(h_cnt_q) < H_END);
  assign v_act  = (32'(v_cnt_q) >= V_START) && (32'(v_cnt_q) < V_END);
  assign x_base = CW'((32'(h_cnt_q) - H_START) * PORTS);
  assign y_base = CW'(32'(v_cnt_q) - V_START);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_fs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_mode <= 3'd0;
      s1_x    <= '0;
      s1_y    <= '0;
    end else begin
      // mode_d, not mode_q, so the new pattern lines up with the frm_st it belongs to.
      s1_mode <= mode_d;
      if (!en || !en_q) begin
        s1_fs <= 1'b0;
        s1_de <= 1'b0;
        s1_hs <= 1'b0;
        s1_vs <= 1'b0;
        s1_x  <= '0;
        s1_y  <= '0;
      end else begin
        s1_fs <= frame_start;
        s1_de <= h_act && v_act;
        s1_hs <= 32'(h_cnt_q) < H_SYNC;
        s1_vs <= 32'(v_cnt_q) < V_PW;
        s1_x  <= x_base;
        s1_y  <= y_base;
      end
    end
  end

  // Stage 2: per-port pattern generation.
  logic [PORTS*3*BPC-1:0] data_d;
  logic [CW-1:0]          px;
  logic [2:0]             rgb, bar;
  logic [BPC-1:0]         lvl;
  logic                   grey;
  logic                   unused_y;

  assign unused_y = ^s1_y;

  always_comb begin
    data_d = '0;
    px     = '0;
    rgb    = 3'b000;
    bar    = 3'd0;
    lvl    = '0;
    grey   = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      px   = s1_x + CW'(p);
      bar  = 3'(px / CW'(BAR_W));
      rgb  = 3'b000;
      lvl  = '0;
      grey = 1'b0;
      case (s1_mode)
        3'd0: rgb = 3'b111;
        3'd1: rgb = 3'b100;
        3'd2: rgb = 3'b010;
        3'd3: rgb = 3'b001;
        3'd4: rgb = BAR_RGB[5'(bar) * 5'd3 +: 3];
        3'd5: begin
          grey = 1'b1;
          lvl  = BPC'(px);
        end
        3'd6: rgb = (px[6] ^ s1_y[6]) ? 3'b000 : 3'b111;
        default: begin
          grey = 1'b1;
          lvl  = BPC'(s1_y);
        end
      endcase
      if (grey) begin
        data_d[p*3*BPC +: 3*BPC] = {lvl, lvl, lvl};
      end else begin
        data_d[p*3*BPC +: 3*BPC] = {{BPC{rgb[2]}}, {BPC{rgb[1]}}, {BPC{rgb[0]}}};
      end
    end
    if (!s1_de) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_st <= 1'b0;
      de     <= 1'b0;
      vsync  <= 1'b0;
      hsync  <= 1'b0;
      mode   <= 3'd0;
      data   <= '0;
    end else begin
      mode <= s1_mode;
      if (!en) begin
        frm_st <= 1'b0;
        de     <= 1'b0;
        vsync  <= 1'b0;
        hsync  <= 1'b0;
        data   <= '0;
      end else begin
        frm_st <= s1_fs;
        de     <= s1_de;
        vsync  <= s1_vs;
        hsync  <= s1_hs;
        data   <= data_d;
      end
    end
  end

endmodule
